hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Generates the stall/flush controls sampled by the ID/EX pipeline register, plus hold controls for the PC and the IF/ID register.
- Detects three conditions:
  - load-use hazards between ID and EX;
  - taken branch/jump redirects resolved in EX;
  - multi-cycle data-memory waits.
- Also keeps saturating stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles flush is held after a redirect (legal 1..3)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rs1  in  5  source register 1 of the instruction in ID
- rs2  in  5  source register 2 of the instruction in ID
- useRs1  in  1  instruction in ID reads rs1
- useRs2  in  1  instruction in ID reads rs2
- rd_ID_EX  in  5  destination register of the instruction in EX
- memRead_ID_EX  in  1  instruction in EX is a load
- branchTaken_EX  in  1  branch condition resolved taken in EX
- jump_ID_EX  in  1  instruction in EX is JAL/JALR
- memBusy  in  1  data memory not ready; pipeline must freeze
- cntClr  in  1  synchronous clear of both counters
- holdPC  out  1  PC keeps its value
- hold_IF_ID  out  1  IF/ID register keeps its value
- stall  out  1  insert bubble into ID/EX (drives ID/EX stall)
- flush_IF_ID  out  1  zero IF/ID register
- flush  out  1  zero ID/EX register (drives ID/EX flush)
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- stallCount  out  CNT_W  cycles lost to stalls/freezes, saturating
- flushCount  out  CNT_W  redirect events, saturating

Behaviour:
- State machine: RUN, FLUSH, MEMWAIT; 2-bit state register. A flushRem down-counter (2 bits) tracks remaining flush cycles.
- Control outputs are combinational from current state and inputs; they must be valid before the next clk edge.
- While reset=0 (asynchronous):
  - state=RUN, flushRem=0, stallCount=0, flushCount=0;
  - all control outputs are forced 0.
- Priority within any cycle: memBusy > redirect > load-use.
- MEMWAIT condition (memBusy=1, any state):
  - freeze=1, holdPC=1, hold_IF_ID=1;
  - stall=0, flush_IF_ID=0, flush=0;
  - next state MEMWAIT; flushRem is held.
- MEMWAIT exit (memBusy=0):
  - return to FLUSH if flushRem!=0, else to RUN;
  - evaluate that cycle normally.
- Redirect condition: redir = branchTaken_EX | jump_ID_EX, evaluated only in RUN with memBusy=0.
  - Same cycle: flush_IF_ID=1, flush=1; load-use is ignored, so stall=0 and no hold.
  - flushCount increments by 1.
  - If FLUSH_CYCLES>1: flushRem <= FLUSH_CYCLES-1 and next state FLUSH; else stay RUN.
- FLUSH state:
  - flush_IF_ID=1, flush=1; flushRem decrements each non-frozen cycle.
  - Go to RUN when flushRem reaches 0.
  - redir is ignored, because the EX slot is already squashed.
- Load-use condition, RUN only, no memBusy, no redirect:
  - lu = memRead_ID_EX & (rd_ID_EX!=0) & ((useRs1 & rs1==rd_ID_EX) | (useRs2 & rs2==rd_ID_EX)).
  - Response: holdPC=1, hold_IF_ID=1, stall=1 for exactly that cycle.
  - The next cycle naturally clears lu because the bubble has replaced the load in EX.
  - rd_ID_EX=0 never stalls.
- stallCount increments each cycle in which holdPC=1, from load-use or freeze.
- Counters saturate at 2^CNT_W-1 with no wrap.
- cntClr=1 zeros both counters on the next edge and overrides any increment that cycle.
- Reset asserted mid-FLUSH or mid-MEMWAIT aborts immediately: outputs go to 0 and the pending flush is discarded.

Test Plan:
- Load-use:
  - memRead_ID_EX=1, rd_ID_EX=5, rs1=5, useRs1=1 -> holdPC=hold_IF_ID=stall=1 for one cycle.
  - Next cycle rd_ID_EX=0 -> all 0; stallCount=1.
- x0 and unused source:
  - rd_ID_EX=0, rs1=0, memRead=1 -> no stall.
  - rs2=7=rd_ID_EX with useRs2=0 -> no stall.
- Redirect beats load-use: branchTaken_EX=1 with a load-use match -> flush_IF_ID=flush=1, stall=0, holdPC=0; flushCount=1.
- FLUSH_CYCLES=3: jump_ID_EX pulse -> flush held 3 consecutive cycles.
  - memBusy=1 in the 2nd cycle for 4 cycles -> freeze=1, flush=0 for those cycles.
  - Afterwards flush resumes for 2 more cycles; stallCount=4.
- Saturation and clear, CNT_W=4:
  - 20 load-use cycles -> stallCount=15.
  - cntClr=1 while a stall is active -> stallCount=0 on the next edge.
- Reset mid-FLUSH: assert reset=0 asynchronously during FLUSH -> all outputs 0 immediately; after release, state RUN and counters 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall/flush/freeze generation for the
// 5-stage RV32 core, with saturating stall and flush event counters.
//
// Ports:
//   clk, reset (async, active-low)
//   rs1, rs2, useRs1, useRs2     : ID-stage source operands
//   rd_ID_EX, memRead_ID_EX      : EX-stage destination / load flag
//   branchTaken_EX, jump_ID_EX   : EX-stage redirect sources
//   memBusy                      : data memory wait, freezes the pipe
//   cntClr                       : synchronous clear of both counters
//   holdPC, hold_IF_ID, stall,
//   flush_IF_ID, flush, freeze   : pipeline control outputs
//   stallCount, flushCount       : saturating performance counters

module hazard_ctrl_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic             useRs1,
    input  logic             useRs2,
    input  logic [4:0]       rd_ID_EX,
    input  logic             memRead_ID_EX,
    input  logic             branchTaken_EX,
    input  logic             jump_ID_EX,
    input  logic             memBusy,
    input  logic             cntClr,
    output logic             holdPC,
    output logic             hold_IF_ID,
    output logic             stall,
    output logic             flush_IF_ID,
    output logic             flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_flushRem;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    state_t     w_eff;
    state_t     w_state_nxt;
    logic [1:0] w_rem_nxt;
    logic       w_redir;
    logic       w_lu;
    logic       w_redir_evt;
    logic       w_holdPC;
    logic       w_hold_IF_ID;
    logic       w_stall;
    logic       w_flush_IF_ID;
    logic       w_flush;
    logic       w_freeze;

    assign w_redir = branchTaken_EX | jump_ID_EX;

    assign w_lu = memRead_ID_EX & (rd_ID_EX != 5'd0) &
                  ((useRs1 & (rs1 == rd_ID_EX)) |
                   (useRs2 & (rs2 == rd_ID_EX)));

    // Leaving MEMWAIT resumes whatever the freeze interrupted, so the
    // cycle is evaluated as FLUSH or RUN depending on pending flushes.
    always_comb begin
        w_eff = r_state;
        if (r_state == MEMWAIT) begin
            w_eff = (r_flushRem != 2'd0) ? FLUSH : RUN;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_flushRem <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_flushRem <= w_rem_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = w_eff;
        w_rem_nxt   = r_flushRem;
        w_redir_evt = 1'b0;
        if (memBusy) begin
            w_state_nxt = MEMWAIT;
        end else begin
            case (w_eff)
                FLUSH: begin
                    w_rem_nxt   = r_flushRem - 2'd1;
                    w_state_nxt = (r_flushRem == 2'd1) ? RUN : FLUSH;
                end
                RUN: begin
                    if (w_redir) begin
                        w_redir_evt = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_rem_nxt   = FLUSH_INIT;
                            w_state_nxt = FLUSH;
                        end
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        w_holdPC      = 1'b0;
        w_hold_IF_ID  = 1'b0;
        w_stall       = 1'b0;
        w_flush_IF_ID = 1'b0;
        w_flush       = 1'b0;
        w_freeze      = 1'b0;
        if (memBusy) begin
            w_freeze     = 1'b1;
            w_holdPC     = 1'b1;
            w_hold_IF_ID = 1'b1;
        end else if (w_eff == FLUSH) begin
            w_flush_IF_ID = 1'b1;
            w_flush       = 1'b1;
        end else if (w_redir) begin
            w_flush_IF_ID = 1'b1;
            w_flush       = 1'b1;
        end else if (w_lu) begin
            w_holdPC     = 1'b1;
            w_hold_IF_ID = 1'b1;
            w_stall      = 1'b1;
        end
    end

    // Reset must silence the controls even though they are combinational.
    assign holdPC      = reset & w_holdPC;
    assign hold_IF_ID  = reset & w_hold_IF_ID;
    assign stall       = reset & w_stall;
    assign flush_IF_ID = reset & w_flush_IF_ID;
    assign flush       = reset & w_flush;
    assign freeze      = reset & w_freeze;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else if (cntClr) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (w_holdPC && (r_stallCount != CNT_MAX)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (w_redir_evt && (r_flushCount != CNT_MAX)) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end
    end

    assign stallCount = r_stallCount;
    assign flushCount = r_flushCount;

endmodule
